// File: rtl/complex_window_buffer.sv
// complex_window_buffer: ping-pong dual-bank store of N-lane complex words.
// One bank takes writes from the upstream stage while the other serves
// WIN-word sliding-window reads with fixed two-cycle latency. A window may
// zero-fill or wrap past the end of the bank.

// Address generator for one window element at fixed offset K from the base.
module cwb_elem #(
  parameter int AW    = 11,
  parameter int DEPTH = 1232,
  parameter int K     = 0
) (
  input  logic [AW-1:0] base,
  input  logic          wrap,
  output logic [AW-1:0] idx,
  output logic          zero
);
  localparam logic [AW:0] DEP = (AW+1)'(DEPTH);
  localparam logic [AW:0] OFF = (AW+1)'(K);

  logic [AW:0] a;

  // One extra bit keeps base+K exact. Because WIN <= DEPTH, a single
  // subtraction always brings a wrapped address back into range.
  always_comb begin
    a    = {1'b0, base} + OFF;
    zero = ({1'b0, base} >= DEP) || ((a >= DEP) && !wrap);
    idx  = (a < DEP) ? AW'(a) : AW'(a - DEP);
  end
endmodule

module complex_window_buffer #(
  parameter int BIT_WIDTH  = 11,
  parameter int N          = 16,
  parameter int DEPTH      = 1232,
  parameter int WIN        = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [2*N*BIT_WIDTH-1:0]      wr_data,
  input  logic                          swap,
  input  logic                          rd_req,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  input  logic                          wrap_en,
  output logic                          rd_valid,
  output logic [WIN*2*N*BIT_WIDTH-1:0]  rd_data,
  output logic                          wr_bank,
  output logic [ADDR_WIDTH:0]           wr_count,
  output logic                          wr_full,
  output logic                          wr_oob
);
  localparam int W  = 2*N*BIT_WIDTH;
  localparam int AW = ADDR_WIDTH;
  // vld_pipe[0] marks the S1 stage and vld_pipe[STAGES] marks the S2 output.
  localparam int STAGES = 1;
  localparam logic [AW:0] DEP = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wrap;
    logic          bank;
  } rd_req_t;

  logic [W-1:0]             mem [2][DEPTH];
  logic                     wr_ok;
  rd_req_t                  s1_q;
  logic [STAGES:0]          vld_pipe;
  logic [WIN-1:0][AW-1:0]   elem_idx;
  logic [WIN-1:0]           elem_zero;
  logic [WIN-1:0][W-1:0]    win_q;

  assign wr_ok   = wr_en && ({1'b0, wr_addr} < DEP);
  assign wr_full = (wr_count == DEP);

  // Storage is intentionally not reset, so contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_bank][wr_addr] <= wr_data;
  end

  // Bank ownership, accepted-write count and reject pulse. On a swap, the
  // count clears even if a write lands in the old bank in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank  <= 1'b0;
      wr_count <= '0;
      wr_oob   <= 1'b0;
    end else begin
      wr_oob <= wr_en && !wr_ok;
      if (swap) begin
        wr_bank  <= ~wr_bank;
        wr_count <= '0;
      end else if (wr_ok && (wr_count != DEP)) begin
        wr_count <= wr_count + 1'b1;
      end
    end
  end

  // S1: capture the request and the read bank as seen before any swap this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_req};
      if (rd_req) begin
        s1_q.addr <= rd_addr;
        s1_q.wrap <= wrap_en;
        s1_q.bank <= ~wr_bank;
      end
    end
  end

  for (genvar k = 0; k < WIN; k++) begin : g_elem
    cwb_elem #(.AW(AW), .DEPTH(DEPTH), .K(k)) u_elem (
      .base (s1_q.addr),
      .wrap (s1_q.wrap),
      .idx  (elem_idx[k]),
      .zero (elem_zero[k])
    );
  end

  // S2: fetch the window. Writes at this same edge are not yet visible.
  // The window holds its value when no request is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= '0;
    end else if (vld_pipe[0]) begin
      for (int k = 0; k < WIN; k++)
        win_q[k] <= elem_zero[k] ? '0 : mem[s1_q.bank][elem_idx[k]];
    end
  end

  assign rd_valid = vld_pipe[STAGES];
  assign rd_data  = win_q;
endmodule

// File: tb/tb_complex_window_buffer.sv
// Bench for complex_window_buffer: directed test-plan items plus a random
// phase. Everything is checked every cycle against a bank/array reference model.
module tb_complex_window_buffer;
  localparam int BW    = 11;
  localparam int N     = 16;
  localparam int DEPTH = 1232;
  localparam int WIN   = 32;
  localparam int AW    = 11;
  localparam int W     = 2*N*BW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [W-1:0]      wr_data = '0;
  logic              swap = 1'b0;
  logic              rd_req = 1'b0;
  logic [AW-1:0]     rd_addr = '0;
  logic              wrap_en = 1'b0;
  logic              rd_valid;
  logic [WIN*W-1:0]  rd_data;
  logic              wr_bank;
  logic [AW:0]       wr_count;
  logic              wr_full;
  logic              wr_oob;

  complex_window_buffer #(
    .BIT_WIDTH(BW), .N(N), .DEPTH(DEPTH), .WIN(WIN), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap(swap),
    .rd_req(rd_req), .rd_addr(rd_addr), .wrap_en(wrap_en),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_bank(wr_bank), .wr_count(wr_count), .wr_full(wr_full), .wr_oob(wr_oob)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: two plain arrays plus the observable state.
  logic [W-1:0] mdl [2][DEPTH];
  int           m_bank, m_count;
  bit           m_oob, m_vld;
  logic [W-1:0] m_win [WIN];
  bit           p_vld, p_wrap;
  int           p_addr, p_bank;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] d;
    for (int i = 0; i < W/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [W-1:0] ref_elem(int base, bit wrap, int bank, int k);
    int a;
    a = base + k;
    if (base >= DEPTH) return '0;
    if (a < DEPTH)     return mdl[bank][a];
    if (wrap)          return mdl[bank][a - DEPTH];
    return '0;
  endfunction

  task automatic model_reset();
    m_bank = 0; m_count = 0; m_oob = 0; m_vld = 0; p_vld = 0;
    for (int k = 0; k < WIN; k++) m_win[k] = '0;
  endtask

  task automatic check_all();
    chk("rd_valid", W'(rd_valid), W'(m_vld));
    chk("wr_bank",  W'(wr_bank),  W'(m_bank));
    chk("wr_count", W'(wr_count), W'(m_count));
    chk("wr_full",  W'(wr_full),  W'(m_count == DEPTH));
    chk("wr_oob",   W'(wr_oob),   W'(m_oob));
    for (int k = 0; k < WIN; k++)
      chk($sformatf("rd_data[%0d]", k), rd_data[k*W +: W], m_win[k]);
  endtask

  // One clock: the window for last cycle's request uses memory as it stood
  // before this edge's write. Then the model applies this cycle's inputs.
  task automatic cyc();
    logic [W-1:0] nw [WIN];
    bit nv;
    nv = p_vld;
    for (int k = 0; k < WIN; k++) nw[k] = nv ? ref_elem(p_addr, p_wrap, p_bank, k) : '0;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_vld = nv;
      if (nv) m_win = nw;
      p_vld  = rd_req;
      p_addr = int'(rd_addr);
      p_wrap = wrap_en;
      p_bank = 1 - m_bank;
      m_oob  = wr_en && (int'(wr_addr) >= DEPTH);
      if (wr_en && int'(wr_addr) < DEPTH) mdl[m_bank][wr_addr] = wr_data;
      if (swap) begin
        m_bank  = 1 - m_bank;
        m_count = 0;
      end else if (wr_en && int'(wr_addr) < DEPTH && m_count < DEPTH) begin
        m_count++;
      end
    end
    #1 check_all();
  endtask

  task automatic idle(int n);
    wr_en = 0; swap = 0; rd_req = 0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic rd(int a, bit w);
    rd_req = 1; rd_addr = AW'(a); wrap_en = w;
  endtask

  initial begin
    model_reset();
    #2 rst = 1;
    #2 check_all();
    cyc(); cyc();
    #1 rst = 0;

    // Fill bank 0 with word = address, then swap.
    for (int a = 0; a < DEPTH; a++) begin
      wr_en = 1; wr_addr = AW'(a); wr_data = W'(a);
      cyc();
    end
    idle(1);
    swap = 1; cyc(); idle(1);

    // Plain read, then a tail window with zero-fill and then with wrap.
    rd(5, 0); cyc(); idle(3);
    rd(1220, 0); cyc(); rd(1220, 1); cyc(); idle(3);

    // Rejected write, then an out-of-range window.
    wr_en = 1; wr_addr = AW'(DEPTH); wr_data = rand_word(); cyc(); idle(2);
    rd(1300, 1); cyc(); idle(3);

    // Fill bank 1 with random data while reading bank 0.
    for (int a = 0; a < DEPTH; a++) begin
      wr_en = 1; wr_addr = AW'(a); wr_data = rand_word();
      rd_req = $urandom_range(0, 1);
      rd_addr = AW'($urandom_range(0, 1300));
      wrap_en = $urandom_range(0, 1);
      cyc();
    end
    idle(2);

    // Same-cycle swap and read: the read uses the pre-swap read bank.
    swap = 1; rd(100, 0); cyc(); idle(3);
    // Same-cycle swap and write: the data lands in the old bank and the count clears.
    swap = 1; wr_en = 1; wr_addr = 7; wr_data = rand_word(); cyc(); idle(1);
    rd(0, 0); cyc(); idle(3);

    // Random mix of writes, swaps and reads.
    for (int i = 0; i < 1500; i++) begin
      wr_en   = $urandom_range(0, 1);
      wr_addr = AW'($urandom_range(0, 1240));
      wr_data = rand_word();
      swap    = ($urandom_range(0, 19) == 0);
      rd_req  = $urandom_range(0, 1);
      rd_addr = AW'($urandom_range(0, 1300));
      wrap_en = $urandom_range(0, 1);
      cyc();
    end
    idle(3);

    // Reset with reads in flight: no late rd_valid, and memory survives.
    rd(3, 0); cyc();
    rd(4, 1);
    #3 rst = 1;
    model_reset();
    #1 check_all();
    rd(5, 0); cyc();
    rd_req = 0; cyc();
    rst = 0;
    idle(3);
    rd(0, 0); cyc(); idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
